// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - decode/writeback bus for the scoreboarded register file
interface register_file_scoreboard_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_READ_PORTS*SEL_W-1:0]       rd_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data;
    logic [NUM_READ_PORTS-1:0]             rd_busy;
    logic [NUM_WRITE_PORTS-1:0]            wr_en;
    logic [NUM_WRITE_PORTS*SEL_W-1:0]      wr_sel;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data;
    logic                                  rsv_en;
    logic [SEL_W-1:0]                      rsv_sel;
    logic                                  rsv_ok;
    logic [NUM_REGS-1:0]                   busy_vec;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        input  rd_data, rd_busy, rsv_ok, busy_vec
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        output rd_data, rd_busy, rsv_ok, busy_vec
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - multi-port register file with write forwarding and busy scoreboard
module register_file_scoreboard #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ZERO_REG_EN     = 1
) (
    input logic                        clk,
    input logic                        rst_n,
    register_file_scoreboard_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0] wr_val [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_hit;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   rsv_set;

    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return (int'(sel) < NUM_REGS) && !((ZERO_REG_EN != 0) && (sel == '0));
    endfunction

    // Per-register write decode; ascending port order lets the highest port win.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_val[r] = '0;
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (bus.wr_en[k] && sel_valid(bus.wr_sel[k*SEL_W +: SEL_W]) &&
                    (int'(bus.wr_sel[k*SEL_W +: SEL_W]) == r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Reads mux over a one-hot decode so out-of-range selects never index the arrays.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rst_n && sel_valid(bus.rd_sel[p*SEL_W +: SEL_W]) &&
                    (int'(bus.rd_sel[p*SEL_W +: SEL_W]) == r)) begin
                    bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_hit[r] ? wr_val[r] : regs[r];
                    bus.rd_busy[p] = busy[r] && !wr_hit[r];
                end
            end
        end
    end

    // A retiring write frees the register in the same cycle it is re-reserved.
    always_comb begin
        rsv_set = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            rsv_set[r] = rst_n && bus.rsv_en && sel_valid(bus.rsv_sel) &&
                         (int'(bus.rsv_sel) == r) && (!busy[r] || wr_hit[r]);
        end
        bus.rsv_ok   = |rsv_set;
        bus.busy_vec = busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
            busy <= (busy & ~wr_hit) | rsv_set;
        end
    end
endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised successor to the fixed five-read/one-write register file. Read port count, write port count, register count and data width are all parameters.
- Adds same-cycle write-to-read forwarding.
- Adds a pending-write scoreboard (busy bits) so the decode stage can detect RAW/WAW hazards without a separate unit.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_WIDTH, 32: width of each register.
- NUM_REGS, 16: number of architectural registers.
- NUM_READ_PORTS, 5: read ports (default covers ra, rb, rc, cond_ra, cond_rb).
- NUM_WRITE_PORTS, 2: independent write ports.
- ZERO_REG_EN, 1: when 1, register 0 is hardwired to zero and never busy.
- SEL_W, $clog2(NUM_REGS): derived local parameter, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_sel  in  NUM_READ_PORTS*SEL_W  read selects, port p at bits [p*SEL_W +: SEL_W]
- rd_data  out  NUM_READ_PORTS*DATA_WIDTH  read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  out  NUM_READ_PORTS  1 = selected register has an outstanding reservation not retired this cycle
- wr_en  in  NUM_WRITE_PORTS  per-port write enable
- wr_sel  in  NUM_WRITE_PORTS*SEL_W  write selects
- wr_data  in  NUM_WRITE_PORTS*DATA_WIDTH  write data
- rsv_en  in  1  request to mark rsv_sel as pending
- rsv_sel  in  SEL_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_vec  out  NUM_REGS  current scoreboard state

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers and all busy bits clear to 0.
  - While reset is asserted: rd_data = 0, rd_busy = 0, rsv_ok = 0, busy_vec = 0.
  - Deassertion is sampled synchronously; the first write lands on the first rising edge with rst_n high.
- Valid select: sel < NUM_REGS. Additionally, when ZERO_REG_EN = 1, sel must be nonzero.
- Invalid selects:
  - Reads return 0 with busy 0.
  - Writes are ignored.
  - Reservations are rejected.
- Writes:
  - Registered at posedge for each k with wr_en[k] = 1 and a valid wr_sel[k].
  - If two ports target the same register in one cycle, the highest-index port wins.
- Reads are combinational, with forwarding:
  - If any enabled valid write port targets rd_sel[p] this cycle, rd_data[p] = that port's wr_data (highest-index port wins).
  - Otherwise rd_data[p] = stored value.
  - Zero read-after-write latency.
- Scoreboard set (next edge): busy[r] is set when rsv_ok = 1 and rsv_sel = r.
- Scoreboard clear (next edge): busy[r] is cleared when any enabled valid write targets r.
- Simultaneous set and clear of the same register: set wins, so busy stays 1 (an older producer retires while a new one issues).
- rsv_ok = rsv_en && valid(rsv_sel) && (!busy[rsv_sel] || a write to rsv_sel occurs this cycle).
  - A rejected reservation has no state effect. The requester holds and retries (WAW stall).
- rd_busy[p] = busy[rd_sel[p]] && !(a write to rd_sel[p] this cycle).
  - When forwarding, the forwarded data is valid.
  - A reservation made this cycle does not affect rd_busy until the next cycle.
- busy_vec reflects registered state only; no forwarding is applied.
- Arithmetic: none. Data passes through unmodified, with no width conversion.

Test Plan:
1. Reset, then read all ports:
   - Assert rst_n = 0 mid-cycle after prior writes -> rd_data = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
2. Forwarding:
   - Write r3 = 0xDEADBEEF on port 0 with rd_sel[2] = 3 in the same cycle -> rd_data[2] = 0xDEADBEEF in that cycle and on all following cycles.
3. Write conflict:
   - Port 0 writes r5 = 0x11 and port 1 writes r5 = 0x22 in the same cycle -> forwarded value and stored value are both 0x22.
4. Scoreboard:
   - Reserve r7 -> rsv_ok = 1, and the next cycle busy_vec[7] = 1 and rd_busy = 1 on any port reading r7.
   - Reserve r7 again -> rsv_ok = 0.
   - Write r7 = 0x5 -> rd_busy = 0 that cycle with data 0x5, and busy_vec[7] = 0 the next cycle.
5. Set/clear collision:
   - With r9 busy, write r9 and reserve r9 in the same cycle -> rsv_ok = 1 and busy_vec[9] stays 1.
6. Zero register (ZERO_REG_EN = 1):
   - Write r0 = 0xFFFFFFFF and reserve r0 -> rd_data for r0 = 0, rsv_ok = 0, busy_vec[0] = 0.
   - With NUM_REGS = 12: rd_sel = 13 -> rd_data = 0, rd_busy = 0.
